lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store unit controller. It consumes the memory-side control fields produced by instruction decode: store enable, store size code, load type code, and a load enable.
- Per access it computes byte lanes, runs a request/acknowledge transaction to data memory with variable latency, and returns sign- or zero-extended load data.
- Sits between the execute-stage ALU address/rs2 data and the DMEM port. Raises a stall while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for i_mem_ack before abort; must be >=2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ld_en  in  1  current instruction is a load
- i_wren  in  1  current instruction is a store
- i_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- i_st_type  in  3  000 SB, 001 SH, 010 SW
- i_addr  in  32  effective byte address (ALU result)
- i_st_data  in  32  rs2 store data
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  1 write, 0 read
- o_mem_addr  out  32  word-aligned address {i_addr[31:2],2'b00}
- o_mem_bmask  out  4  byte-lane write enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_ack  in  1  transaction complete; read data valid same cycle
- i_mem_rdata  in  32  read word
- o_stall  out  1  freeze upstream pipeline (combinational)
- o_ld_data  out  32  formatted load result (registered)
- o_done  out  1  one-cycle pulse: access finished (ack or timeout)
- o_misalign  out  1  one-cycle pulse: misaligned or illegal type; no bus access
- o_bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset values: every registered output is 0; state is IDLE; counter is 0. Reset wins over all other events in the same cycle.
- FSM states: IDLE, ACCESS, RESP.
- Start condition in IDLE: (i_wren | i_ld_en) & legal & aligned. If i_wren and i_ld_en are both high, the access is a store and i_ld_en is ignored.
- Legality:
  - Store codes 011..111 are illegal.
  - Load codes 011, 110, 111 are illegal.
- Alignment:
  - Half accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Byte accesses are always aligned.
- IDLE with an illegal or misaligned access: no request is issued; o_misalign pulses next cycle; o_stall stays 0; o_ld_data is unchanged.
- IDLE -> ACCESS on start. On that edge, o_mem_req, o_mem_we, o_mem_addr, o_mem_bmask and o_mem_wdata are registered, and the counter clears.
- o_stall = (IDLE & start) | ACCESS. The pipeline holds all inputs stable while stalled.
- ACCESS:
  - Request fields are held constant while waiting. Counter increments every cycle without ack.
  - On i_mem_ack: deassert o_mem_req. For loads, register the formatted i_mem_rdata into o_ld_data. Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack: deassert o_mem_req, set o_ld_data=0 for loads, pulse o_bus_err, go to RESP.
- RESP: o_done=1 for this single cycle; o_stall=0 so the pipeline advances; unconditionally go to IDLE. The held instruction is not restarted.
- Store lanes (o = addr[1:0]):
  - SB: bmask = 1<<o, wdata = {4{st_data[7:0]}}.
  - SH: bmask = o[1] ? 1100 : 0011, wdata = {2{st_data[15:0]}}.
  - SW: bmask = 1111, wdata = st_data.
- Load extract:
  - Byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Reads drive bmask = 0000.
- i_mem_ack outside ACCESS is ignored.
- Reset mid-ACCESS: o_mem_req drops on that edge; a late ack is ignored.

Decomposition:
- lsu_pkg holds:
  - load_type_e (LB, LH, LW, LBU, LHU)
  - store_type_e (SB, SH, SW)
  - lsu_state_e (IDLE, ACCESS, RESP)
  - constant TIMEOUT_DEFAULT = 16
- Sub-module lsu_lane_fmt (combinational): alignment/legality check, bmask/wdata generation, load extraction and extension. Instantiated once; the FSM, counter and registers stay in lsu_ctrl.

Test Plan:
- SB addr 0x1003, st_data 0x000000A5, ack after 3 cycles -> mem_addr 0x1000, bmask 1000, wdata 0xA5A5A5A5, we=1, o_stall high 4 cycles, o_done on the cycle after ack.
- LB addr 0x2001, rdata 0x0000_8000 -> o_ld_data 0xFFFFFF80; LBU same stimulus -> 0x00000080; LHU addr 0x2002, rdata 0xBEEF1234 -> 0x0000BEEF.
- LW addr 0x3002 -> no o_mem_req, o_misalign pulse 1 cycle, o_stall 0; SH addr 0x3001 -> same; i_st_type 011 -> same.
- LW with ack never asserted, TIMEOUT_CYCLES=16 -> o_bus_err and o_done pulse after 16 ACCESS cycles, o_ld_data 0, o_mem_req low afterward.
- i_wren=1 and i_ld_en=1, SW addr 0x4000, data 0x12345678 -> write with bmask 1111, o_ld_data unchanged.
- i_reset during ACCESS, then i_mem_ack one cycle later -> o_mem_req 0, state IDLE, o_done/o_ld_data stay 0; a back-to-back LW completes normally after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access codes, FSM states, bus request payload.
package lsu_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Request fields held on the DMEM port for the life of a transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational lane formatting: access legality/alignment, store lanes, load extraction.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic        i_wren,
  input  logic [2:0]  i_load_type,
  input  logic [2:0]  i_st_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic        o_ok_c,
  output logic [3:0]  o_bmask_c,
  output logic [31:0] o_wdata_c,
  output logic [31:0] o_ld_data_c
);

  logic        w_legal;
  logic        w_aligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Legal code and natural alignment for the selected access; a store takes priority over a load.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (i_wren) begin
      case (i_st_type)
        SB:      begin w_legal = 1'b1; w_aligned = 1'b1;              end
        SH:      begin w_legal = 1'b1; w_aligned = ~i_off[0];         end
        SW:      begin w_legal = 1'b1; w_aligned = (i_off == 2'b00);  end
        default: begin w_legal = 1'b0; w_aligned = 1'b0;              end
      endcase
    end else begin
      case (i_load_type)
        LB, LBU: begin w_legal = 1'b1; w_aligned = 1'b1;              end
        LH, LHU: begin w_legal = 1'b1; w_aligned = ~i_off[0];         end
        LW:      begin w_legal = 1'b1; w_aligned = (i_off == 2'b00);  end
        default: begin w_legal = 1'b0; w_aligned = 1'b0;              end
      endcase
    end
  end

  assign o_ok_c = w_legal & w_aligned;

  // Store byte lanes and lane-replicated write data.
  always_comb begin
    o_bmask_c = 4'b0000;
    o_wdata_c = 32'h0;
    case (i_st_type)
      SB: begin
        o_bmask_c = 4'b0001 << i_off;
        o_wdata_c = {4{i_st_data[7:0]}};
      end
      SH: begin
        o_bmask_c = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata_c = {2{i_st_data[15:0]}};
      end
      SW: begin
        o_bmask_c = 4'b1111;
        o_wdata_c = i_st_data;
      end
      default: begin
        o_bmask_c = 4'b0000;
        o_wdata_c = 32'h0;
      end
    endcase
  end

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Load extraction with sign or zero extension.
  always_comb begin
    o_ld_data_c = 32'h0;
    case (i_load_type)
      LB:      o_ld_data_c = {{24{w_byte[7]}}, w_byte};
      LH:      o_ld_data_c = {{16{w_half[15]}}, w_half};
      LW:      o_ld_data_c = i_rdata;
      LBU:     o_ld_data_c = {24'h0, w_byte};
      LHU:     o_ld_data_c = {16'h0, w_half};
      default: o_ld_data_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one DMEM request/ack transaction per legal aligned access.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ld_en,
  input  logic        i_wren,
  input  logic [2:0]  i_load_type,
  input  logic [2:0]  i_st_type,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_done,
  output logic        o_misalign,
  output logic        o_bus_err
);

  lsu_state_e         r_state, w_state_nxt;
  logic               r_req, w_req_nxt;
  mem_req_t           r_pl, w_pl_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]        r_ld_data, w_ld_data_nxt;
  logic               r_done, w_done_nxt;
  logic               r_misalign, w_misalign_nxt;
  logic               r_bus_err, w_bus_err_nxt;

  logic               w_active;
  logic               w_ok;
  logic               w_start;
  logic [3:0]         w_bmask;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ld_fmt;

  lsu_lane_fmt u_lane_fmt (
    .i_wren      (i_wren),
    .i_load_type (i_load_type),
    .i_st_type   (i_st_type),
    .i_off       (i_addr[1:0]),
    .i_st_data   (i_st_data),
    .i_rdata     (i_mem_rdata),
    .o_ok_c      (w_ok),
    .o_bmask_c   (w_bmask),
    .o_wdata_c   (w_wdata),
    .o_ld_data_c (w_ld_fmt)
  );

  assign w_active = i_wren | i_ld_en;
  assign w_start  = w_active & w_ok;

  // Next-state and next-register values; pulses default low, everything else holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_pl_nxt       = r_pl;
    w_cnt_nxt      = r_cnt;
    w_ld_data_nxt  = r_ld_data;
    w_done_nxt     = 1'b0;
    w_misalign_nxt = 1'b0;
    w_bus_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt    = ACCESS;
          w_req_nxt      = 1'b1;
          w_pl_nxt.we    = i_wren;
          w_pl_nxt.addr  = {i_addr[31:2], 2'b00};
          w_pl_nxt.bmask = i_wren ? w_bmask : 4'b0000;
          w_pl_nxt.wdata = i_wren ? w_wdata : 32'h0;
          w_cnt_nxt      = '0;
        end else if (w_active) begin
          w_misalign_nxt = 1'b1;
        end
      end
      ACCESS: begin
        if (i_mem_ack) begin
          w_req_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = RESP;
          if (!r_pl.we) w_ld_data_nxt = w_ld_fmt;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_req_nxt     = 1'b0;
          w_done_nxt    = 1'b1;
          w_bus_err_nxt = 1'b1;
          w_state_nxt   = RESP;
          if (!r_pl.we) w_ld_data_nxt = 32'h0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_pl       <= '0;
      r_cnt      <= '0;
      r_ld_data  <= 32'h0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_pl       <= w_pl_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ld_data  <= w_ld_data_nxt;
      r_done     <= w_done_nxt;
      r_misalign <= w_misalign_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  assign o_stall     = ((r_state == IDLE) & w_start) | (r_state == ACCESS);
  assign o_mem_req   = r_req;
  assign o_mem_we    = r_pl.we;
  assign o_mem_addr  = r_pl.addr;
  assign o_mem_bmask = r_pl.bmask;
  assign o_mem_wdata = r_pl.wdata;
  assign o_ld_data   = r_ld_data;
  assign o_done      = r_done;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;

endmodule
